// File: rtl/apb_native_pkg.sv
// Shared definitions for the APB3 -> reg_native bridge.
//   state_e                : bridge FSM state encoding
//   DEFAULT_TIMEOUT_CYCLES : WAIT cycles before a missing ack becomes an error
package apb_native_pkg;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/native_timeout_cnt.sv
// Timeout counter for the WAIT state of apb_native_bridge.
//   clk, rst_n : clock, async active-low reset
//   clear      : zero the count (asserted on the cycle before WAIT entry)
//   enable     : advance the count by one
//   expired    : count has reached TIMEOUT_CYCLES-1
module native_timeout_cnt
    import apb_native_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Saturates at the terminal value so the count can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_native_bridge.sv
// APB3 slave to reg_native master bridge.
// Each APB transfer becomes one single-cycle req_vld pulse on the native side;
// the APB response is returned once ack_vld arrives, or with pslverr after
// TIMEOUT_CYCLES in WAIT. Misaligned byte addresses are errored locally.
//   APB side    : psel, penable, pwrite, paddr, pwdata -> prdata, pready, pslverr
//   native side : req_vld, wr_en, rd_en, addr, wr_data -> ack_vld, rd_data
module apb_native_bridge
    import apb_native_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH+1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  req_vld,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  ack_vld,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    state_e                state, state_nxt;
    logic                  load_req;
    logic                  go_resp;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  expired;

    native_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clr),
        .enable  (cnt_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_req  = 1'b0;
        go_resp   = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                if (psel && penable && !pready) begin
                    if (paddr[1:0] != 2'b00) begin
                        state_nxt = RESP;
                        go_resp   = 1'b1;
                        resp_err  = 1'b1;
                    end else begin
                        state_nxt = REQ;
                        load_req  = 1'b1;
                    end
                end
            end
            REQ: begin
                state_nxt = WAIT;
                cnt_clr   = 1'b1;
            end
            WAIT: begin
                // An ack in the terminal count cycle still completes cleanly.
                if (ack_vld) begin
                    state_nxt = RESP;
                    go_resp   = 1'b1;
                    resp_data = rd_en ? rd_data : '0;
                end else if (expired) begin
                    state_nxt = RESP;
                    go_resp   = 1'b1;
                    resp_err  = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // APB response registers: loaded on RESP entry, so pready spans RESP only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            pready <= go_resp;
            if (go_resp) begin
                pslverr <= resp_err;
                prdata  <= resp_data;
            end
        end
    end

    // Native request registers; addr/wr_data deliberately hold after completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_vld <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            addr    <= '0;
            wr_data <= '0;
        end else begin
            req_vld <= load_req;
            if (load_req) begin
                addr    <= paddr[ADDR_WIDTH+1:2];
                wr_data <= pwdata;
                wr_en   <= pwrite;
                rd_en   <= !pwrite;
            end else if (state == RESP) begin
                wr_en <= 1'b0;
                rd_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_native_bridge.sv
module tb_apb_native_bridge;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          psel, penable, pwrite;
    logic [AW+1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;
    logic          req_vld, wr_en, rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic          ack_vld;
    logic [DW-1:0] rd_data;

    always #5 clk = ~clk;

    apb_native_bridge #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .req_vld (req_vld),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .addr    (addr),
        .wr_data (wr_data),
        .ack_vld (ack_vld),
        .rd_data (rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- native target model ----------------
    logic [DW-1:0] mem [0:63];
    int            ack_dly    = 2;   // 0 = never acknowledge
    int            pend       = 0;
    int            nreq       = 0;
    int            force_req  = 0;
    int            force_seen = 0;
    logic [AW-1:0] cap_addr   = '0;
    logic          cap_wr     = 1'b0;
    logic          cap_rd     = 1'b0;
    logic [DW-1:0] cap_data   = '0;

    initial begin
        ack_vld = 1'b0;
        rd_data = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        forever begin
            @(negedge clk);
            ack_vld = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else if (force_req != force_seen) begin
                force_seen = force_req;
                ack_vld    = 1'b1;
                rd_data    = 32'hBAD0_BAD0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    ack_vld = 1'b1;
                    if (cap_wr) begin
                        mem[cap_addr] = cap_data;
                        rd_data       = 32'h5A5A_5A5A;
                    end else begin
                        rd_data = mem[cap_addr];
                    end
                end
            end
            if (rst_n && req_vld) begin
                nreq++;
                cap_addr = addr;
                cap_wr   = wr_en;
                cap_rd   = rd_en;
                cap_data = wr_data;
                pend     = ack_dly;
            end
        end
    end

    // ---------------- APB master ----------------
    task automatic apb_start(input logic w, input logic [AW+1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
        @(negedge clk);
        penable = 1'b1;
    endtask

    // lat = cycles from the access-phase cycle A to the pready cycle.
    task automatic apb_finish(output logic [DW-1:0] rdat, output logic err, output int lat);
        lat  = 0;
        rdat = '0;
        err  = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (pready) begin
                lat  = i;
                rdat = prdata;
                err  = pslverr;
                break;
            end
        end
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        check("pready_single", 32'(pready), 32'h0);
        check("en_cleared", 32'({wr_en, rd_en}), 32'h0);
    endtask

    task automatic apb_xfer(input logic w, input logic [AW+1:0] a, input logic [DW-1:0] d,
                            output logic [DW-1:0] rdat, output logic err, output int lat);
        apb_start(w, a, d);
        apb_finish(rdat, err, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic          err;
        int            lat;
        int            r0;
        int            hits;

        rst_n   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        repeat (3) @(negedge clk);
        check("rst_pready",  32'(pready),  32'h0);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        check("rst_prdata",  prdata,       32'h0);
        check("rst_req_vld", 32'(req_vld), 32'h0);
        check("rst_en",      32'({wr_en, rd_en}), 32'h0);
        check("rst_addr",    32'(addr),    32'h0);
        check("rst_wr_data", wr_data,      32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // write then read back, 2-cycle-ack target
        ack_dly = 2;
        r0 = nreq;
        apb_xfer(1'b1, 8'h10, 32'hDEAD_BEEF, rd, err, lat);
        check("wr_lat",    32'(lat),        32'd4);
        check("wr_err",    32'(err),        32'h0);
        check("wr_prdata", rd,              32'h0);
        check("wr_nreq",   32'(nreq - r0),  32'd1);
        check("wr_addr",   32'(cap_addr),   32'h04);
        check("wr_wr_en",  32'(cap_wr),     32'h1);
        check("wr_rd_en",  32'(cap_rd),     32'h0);
        check("wr_data",   cap_data,        32'hDEAD_BEEF);

        r0 = nreq;
        apb_xfer(1'b0, 8'h10, 32'h0, rd, err, lat);
        check("rd_lat",    32'(lat),        32'd4);
        check("rd_err",    32'(err),        32'h0);
        check("rd_prdata", rd,              32'hDEAD_BEEF);
        check("rd_nreq",   32'(nreq - r0),  32'd1);
        check("rd_rd_en",  32'(cap_rd),     32'h1);
        check("rd_addr",   32'(cap_addr),   32'h04);

        // timeout, then recovery
        ack_dly = 0;
        r0 = nreq;
        apb_xfer(1'b0, 8'h20, 32'h0, rd, err, lat);
        check("to_lat",    32'(lat),        32'd18);
        check("to_err",    32'(err),        32'h1);
        check("to_prdata", rd,              32'h0);
        check("to_nreq",   32'(nreq - r0),  32'd1);
        ack_dly = 2;
        apb_xfer(1'b0, 8'h10, 32'h0, rd, err, lat);
        check("rec_lat",    32'(lat), 32'd4);
        check("rec_err",    32'(err), 32'h0);
        check("rec_prdata", rd,       32'hDEAD_BEEF);

        // misaligned address
        r0 = nreq;
        apb_xfer(1'b0, 8'h13, 32'h0, rd, err, lat);
        check("mis_lat",    32'(lat),       32'd1);
        check("mis_err",    32'(err),       32'h1);
        check("mis_prdata", rd,             32'h0);
        check("mis_nreq",   32'(nreq - r0), 32'd0);

        // ack coincident with the final timeout cycle
        ack_dly = 16;
        apb_xfer(1'b0, 8'h08, 32'h0, rd, err, lat);
        check("edge_lat",    32'(lat), 32'd18);
        check("edge_err",    32'(err), 32'h0);
        check("edge_prdata", rd,       32'h1000_0002);

        // late ack after timeout must be ignored
        ack_dly = 0;
        apb_xfer(1'b0, 8'h0C, 32'h0, rd, err, lat);
        check("late_to_err", 32'(err), 32'h1);
        repeat (2) @(negedge clk);
        force_req++;
        hits = 0;
        repeat (5) begin
            @(negedge clk);
            if (pready) hits++;
        end
        check("late_no_pready", 32'(hits), 32'h0);
        ack_dly = 2;
        apb_xfer(1'b0, 8'h14, 32'h0, rd, err, lat);
        check("late_next_lat",    32'(lat), 32'd4);
        check("late_next_err",    32'(err), 32'h0);
        check("late_next_prdata", rd,       32'h1000_0005);

        // async reset during WAIT
        ack_dly = 0;
        apb_start(1'b0, 8'h18, 32'h1234_5678);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pready",  32'(pready),  32'h0);
        check("arst_pslverr", 32'(pslverr), 32'h0);
        check("arst_prdata",  prdata,       32'h0);
        check("arst_req_vld", 32'(req_vld), 32'h0);
        check("arst_en",      32'({wr_en, rd_en}), 32'h0);
        check("arst_addr",    32'(addr),    32'h0);
        check("arst_wr_data", wr_data,      32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        force_req++;
        hits = 0;
        repeat (5) begin
            @(negedge clk);
            if (pready) hits++;
        end
        check("arst_stray_ack", 32'(hits), 32'h0);
        check("arst_prdata_hold", prdata, 32'h0);
        ack_dly = 2;
        apb_xfer(1'b1, 8'h3C, 32'hCAFE_F00D, rd, err, lat);
        check("post_wr_lat", 32'(lat),      32'd4);
        check("post_wr_err", 32'(err),      32'h0);
        check("post_wr_addr", 32'(cap_addr), 32'h0F);
        apb_xfer(1'b0, 8'h3C, 32'h0, rd, err, lat);
        check("post_rd_lat",    32'(lat), 32'd4);
        check("post_rd_prdata", rd,       32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_native_bridge.md
# apb_native_bridge

APB3 slave to reg_native master bridge, sitting directly upstream of a reg_native target such as the external memory model or an external register block. It converts each APB transfer into one reg_native request (single-cycle `req_vld` pulse), waits for `ack_vld`, and returns `pready`/`prdata`. A timeout counter turns a never-acknowledged request into an APB slave error so the bus never hangs. Misaligned APB addresses are rejected locally.

## Interface
- `DATA_WIDTH`, 32: APB and native data width.
- `ADDR_WIDTH`, 6: native word-address width; `paddr` is byte-addressed, `ADDR_WIDTH+2` bits.
- `TIMEOUT_CYCLES`, 16: cycles spent in WAIT before error completion; legal range ≥2.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `psel` in 1: APB select.
- `penable` in 1: APB access phase.
- `pwrite` in 1: 1 = write.
- `paddr` in ADDR_WIDTH+2: byte address.
- `pwdata` in DATA_WIDTH: write data.
- `prdata` out DATA_WIDTH: read data, registered.
- `pready` out 1: transfer complete, registered.
- `pslverr` out 1: error, valid only with `pready`.
- `req_vld` out 1: native request, one-cycle pulse.
- `wr_en` out 1: native write strobe.
- `rd_en` out 1: native read strobe.
- `addr` out ADDR_WIDTH: native word address, `paddr[ADDR_WIDTH+1:2]`.
- `wr_data` out DATA_WIDTH: native write data.
- `ack_vld` in 1: native acknowledge.
- `rd_data` in DATA_WIDTH: native read data, valid in the `ack_vld` cycle.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE → REQ when `psel && penable && !pready`.
  - Registers `addr`, `wr_data`, `wr_en = pwrite`, `rd_en = !pwrite`.
  - Drives `req_vld = 1` for the REQ cycle only.
- IDLE → RESP directly when `paddr[1:0] != 0`.
  - No native request is issued.
  - `pslverr = 1`, `prdata = 0`.
- REQ → WAIT unconditionally; the timeout counter is cleared to 0 on entry to WAIT.
- WAIT behaviour:
  - `ack_vld = 1`: go to RESP. `prdata <= rd_data` for reads, `prdata <= 0` for writes; `pslverr = 0`.
  - Else, counter `== TIMEOUT_CYCLES-1`: go to RESP with `pslverr = 1`, `prdata = 0`.
  - Else: counter increments.
  - `ack_vld` wins over timeout in the same cycle.
- RESP → IDLE unconditionally.
  - `pready = 1` for exactly the RESP cycle.
  - `wr_en`/`rd_en` clear on RESP exit.
  - `addr`/`wr_data` hold their last value.
- `ack_vld` is ignored in IDLE, REQ and RESP. A late ack after a timeout must not complete a later transfer.
- Counter width is `$clog2(TIMEOUT_CYCLES)` and never wraps, since it is cleared on WAIT entry.

## Timing
- Reset values: `pready = 0`, `pslverr = 0`, `prdata = 0`, `req_vld = 0`, `wr_en = 0`, `rd_en = 0`, `addr = 0`, `wr_data = 0`; state IDLE, counter 0.
- Access phase begins in cycle A.
  - `req_vld` is high in cycle A+1.
  - With a target acking in cycle A+1+k, `pready` is high in cycle A+2+k.
  - For a 2-cycle-ack target (ack in A+3), `pready` is in A+4.
- Timeout: `pready` with `pslverr` is high in cycle A+2+TIMEOUT_CYCLES.
- Misaligned address: `pready` is high in cycle A+1.
- Outputs to the master change only in RESP; `pready` is never high two consecutive cycles.
- Reset mid-transfer: all outputs return to reset values immediately (async). A subsequent stray `ack_vld` is ignored. The master's abandoned transfer is not completed.
- `psel` dropped by a non-compliant master during WAIT: the transfer still completes to RESP and is then discarded.

## Structure
- Shared package `apb_native_pkg`: state encoding localparams (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, RESP=2'd3) and a default `TIMEOUT_CYCLES`.
- One sub-module: `native_timeout_cnt` (inputs clear/enable, output `expired`), parameterised by `TIMEOUT_CYCLES`.
- The FSM and APB/native registers live in the top.

## Test plan
- Write 0xDEADBEEF to `paddr` 0x10, then read it back → native `addr` 0x04 with `wr_en`, one-cycle `req_vld`; read returns `prdata` 0xDEADBEEF, `pslverr` 0. With a 2-cycle-ack target, `pready` is in A+4 for both.
- Target never acks, `TIMEOUT_CYCLES` 16 → `pready` + `pslverr` in A+18, `prdata` 0. A second transfer with ack restored succeeds.
- Read `paddr` 0x13 → no `req_vld`; `pready` + `pslverr` in A+1.
- `ack_vld` coincident with the final timeout cycle → completion without error, `prdata` = `rd_data`.
- Late ack injected 3 cycles after a timeout completion, in IDLE → ignored; the next read returns its own data.
- `rst_n` asserted during WAIT → all outputs 0 asynchronously; a post-reset ack is ignored; a new transfer completes normally.
